// File: rtl/alu_sequencer.sv
// ALU instruction sequencer: holds a small program in registers and, on
// start, streams entries 0..len to an external ALU one per cycle, optionally
// preceded by a clear (LDI 00). After a one-cycle drain it captures the ALU
// accumulator into result and pulses done. Abort ends a run early.
module alu_sequencer #(
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [11:0]       prog_data,
  input  logic [ADDR_W-1:0] len,
  input  logic              start,
  input  logic              start_clr,
  input  logic              abort,
  output logic [11:0]       alu_inst,
  output logic              alu_inst_en,
  input  logic [7:0]        alu_result,
  output logic [7:0]        result,
  output logic              busy,
  output logic              done,
  output logic              aborted
);

  localparam int              DEPTH    = 1 << ADDR_W;
  localparam logic [11:0]     CLR_INST = 12'h100;
  localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DRAIN = 2'd3
  } state_t;

  state_t            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [7:0]        result_q;
  logic              done_q;
  logic              aborted_q;
  logic [11:0]       mem_q [DEPTH];

  // Program store: writable only while idle, never cleared by reset.
  always_ff @(posedge clock) begin
    if (prog_we && (state_q == IDLE)) begin
      mem_q[prog_addr] <= prog_data;
    end
  end

  // Sequencer FSM with registered result/done/aborted.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      pc_q      <= '0;
      result_q  <= 8'h00;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            pc_q    <= '0;
            state_q <= start_clr ? CLEAR : RUN;
          end
        end
        CLEAR: begin
          if (abort) begin
            state_q   <= IDLE;
            aborted_q <= 1'b1;
          end else begin
            state_q <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            state_q   <= IDLE;
            aborted_q <= 1'b1;
          end else if (pc_q >= len) begin
            // >= rather than == so pc can never run past len, even if len moves.
            state_q <= DRAIN;
          end else begin
            pc_q <= pc_q + PC_ONE;
          end
        end
        DRAIN: begin
          if (abort) begin
            state_q   <= IDLE;
            aborted_q <= 1'b1;
          end else begin
            result_q <= alu_result;
            done_q   <= 1'b1;
            state_q  <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Instruction issue; abort kills the enable in the same cycle.
  always_comb begin
    alu_inst_en = 1'b0;
    alu_inst    = 12'h000;
    if (!abort) begin
      case (state_q)
        CLEAR: begin
          alu_inst_en = 1'b1;
          alu_inst    = CLR_INST;
        end
        RUN: begin
          alu_inst_en = 1'b1;
          alu_inst    = mem_q[pc_q];
        end
        default: begin
          alu_inst_en = 1'b0;
          alu_inst    = 12'h000;
        end
      endcase
    end
  end

  assign busy    = (state_q != IDLE);
  assign result  = result_q;
  assign done    = done_q;
  assign aborted = aborted_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: an external ALU model feeds alu_result, and a
// transaction-level model (queue of expected issue slots) predicts every
// output each cycle. Directed scenarios pin literal values.
module tb_alu_sequencer;

  localparam int AW = 4;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          prog_we = 1'b0;
  logic [AW-1:0] prog_addr = '0;
  logic [11:0]   prog_data = '0;
  logic [AW-1:0] len = '0;
  logic          start = 1'b0;
  logic          start_clr = 1'b0;
  logic          abort = 1'b0;
  logic [11:0]   alu_inst;
  logic          alu_inst_en;
  logic [7:0]    alu_result;
  logic [7:0]    result;
  logic          busy;
  logic          done;
  logic          aborted;

  always #5 clock = ~clock;

  alu_sequencer #(.ADDR_W(AW)) dut (
    .clock(clock), .reset(reset), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .len(len), .start(start), .start_clr(start_clr),
    .abort(abort), .alu_inst(alu_inst), .alu_inst_en(alu_inst_en),
    .alu_result(alu_result), .result(result), .busy(busy), .done(done),
    .aborted(aborted)
  );

  // ALU semantics: 1 LDI, 2 ADD, 3 SUB, 4 AND, 5 OR, 6 XOR, 8 SHL1, else hold.
  function automatic logic [7:0] alu_f(input logic [7:0] acc, input logic [11:0] inst);
    logic [7:0] imm;
    imm = inst[7:0];
    case (inst[11:8])
      4'h1:    return imm;
      4'h2:    return acc + imm;
      4'h3:    return acc - imm;
      4'h4:    return acc & imm;
      4'h5:    return acc | imm;
      4'h6:    return acc ^ imm;
      4'h8:    return {acc[6:0], 1'b0};
      default: return acc;
    endcase
  endfunction

  logic [7:0] alu_acc = 8'h00;
  always @(posedge clock) begin
    if (alu_inst_en) alu_acc <= alu_f(alu_acc, alu_inst);
  end
  assign alu_result = alu_acc;

  // Reference model state
  int          sched[$];      // remaining busy cycles: instruction word, or -1 for drain
  logic [11:0] mmem [16];
  logic [7:0]  m_acc = 8'h00;
  logic [7:0]  m_result = 8'h00;
  logic        m_done = 1'b0;
  logic        m_ab = 1'b0;
  int          n_chk = 0;
  int          n_fail = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int h;
    m_done = 1'b0;
    m_ab   = 1'b0;
    if (!reset) begin
      sched.delete();
      m_result = 8'h00;
    end else if (sched.size() == 0) begin
      if (prog_we) mmem[prog_addr] = prog_data;
      if (start) begin
        if (start_clr) sched.push_back(int'(12'h100));
        for (int i = 0; i <= int'(len); i++) sched.push_back(int'(mmem[i]));
        sched.push_back(-1);
      end
    end else begin
      h = sched.pop_front();
      if (abort) begin
        sched.delete();
        m_ab = 1'b1;
      end else if (h < 0) begin
        m_done   = 1'b1;
        m_result = m_acc;
      end else begin
        m_acc = alu_f(m_acc, 12'(h));
      end
    end
  endtask

  task automatic cmp_cycle();
    logic        busy_e;
    logic        en_e;
    logic [11:0] inst_e;
    logic [27:0] a;
    logic [27:0] e;
    busy_e = (sched.size() != 0);
    en_e   = 1'b0;
    inst_e = 12'h000;
    if (busy_e && !abort && sched[0] >= 0) begin
      en_e   = 1'b1;
      inst_e = 12'(sched[0]);
    end
    a = {2'b00, busy, alu_inst_en, alu_inst, 2'b00, done, aborted, result};
    e = {2'b00, busy_e, en_e, inst_e, 2'b00, m_done, m_ab, m_result};
    chk("cycle{busy,en|inst|done,ab|result}", 32'(a), 32'(e));
  endtask

  task automatic tick();
    @(posedge clock);
    #2;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [11:0] d);
    prog_we   = 1'b1;
    prog_addr = a;
    prog_data = d;
    tick();
    prog_we   = 1'b0;
  endtask

  initial begin
    fork
      forever begin
        @(posedge clock or negedge reset);
        model_step();
      end
      forever begin
        @(negedge clock);
        cmp_cycle();
      end
      begin : stim
        int dn;
        // Reset values
        #1;
        chk("rst busy", busy, 1'b0);
        chk("rst en", alu_inst_en, 1'b0);
        chk("rst inst", alu_inst, 12'h000);
        chk("rst done", done, 1'b0);
        chk("rst aborted", aborted, 1'b0);
        chk("rst result", result, 8'h00);
        tick();
        reset = 1'b1;
        for (int i = 0; i < 16; i++) wr(AW'(i), 12'h000);
        repeat (2) tick();

        // Three-entry program, no clear
        wr(0, 12'h105); wr(1, 12'h203); wr(2, 12'h800);
        len = 2; start = 1'b1; tick(); start = 1'b0;
        @(negedge clock); chk("p1 inst0", alu_inst, 12'h105); chk("p1 en0", alu_inst_en, 1'b1);
        @(negedge clock); chk("p1 inst1", alu_inst, 12'h203);
        @(negedge clock); chk("p1 inst2", alu_inst, 12'h800);
        @(negedge clock); chk("p1 drain en", alu_inst_en, 1'b0); chk("p1 drain busy", busy, 1'b1);
        @(negedge clock); chk("p1 done", done, 1'b1); chk("p1 result", result, 8'h10);
        @(negedge clock); chk("p1 done low", done, 1'b0);
        tick();

        // Clear-prefixed run; write and start in the same cycle
        wr(0, 12'h13C); len = 0; start = 1'b1; tick(); start = 1'b0;
        repeat (4) tick();
        prog_we = 1'b1; prog_addr = 0; prog_data = 12'h207;
        start = 1'b1; start_clr = 1'b1; tick();
        prog_we = 1'b0; start = 1'b0; start_clr = 1'b0;
        @(negedge clock); chk("p2 clr inst", alu_inst, 12'h100); chk("p2 acc before", alu_result, 8'h3C);
        @(negedge clock); chk("p2 inst0", alu_inst, 12'h207);
        @(negedge clock); chk("p2 drain en", alu_inst_en, 1'b0);
        @(negedge clock); chk("p2 done", done, 1'b1); chk("p2 result", result, 8'h07);
        tick();

        // Abort at pc=5 of a 16-entry program
        for (int i = 0; i < 16; i++) wr(AW'(i), 12'h201);
        len = 15; start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        abort = 1'b1;
        @(negedge clock); chk("ab en", alu_inst_en, 1'b0); chk("ab inst", alu_inst, 12'h000);
        @(posedge clock); #2; abort = 1'b0;
        @(negedge clock); chk("ab pulse", aborted, 1'b1); chk("ab busy", busy, 1'b0);
        chk("ab no done", done, 1'b0); chk("ab result held", result, 8'h07);
        @(negedge clock); chk("ab pulse low", aborted, 1'b0);
        tick();

        // start and prog_we while busy are ignored
        wr(0, 12'h105); wr(1, 12'h203); wr(2, 12'h800);
        len = 2; start = 1'b1; tick(); start = 1'b0;
        tick();
        start = 1'b1; prog_we = 1'b1; prog_addr = 0; prog_data = 12'h1FF; tick();
        start = 1'b0; prog_we = 1'b0;
        dn = 0;
        repeat (6) begin
          @(negedge clock);
          if (done) dn++;
        end
        chk("busy-start single done", dn, 1);
        chk("busy-start result", result, 8'h10);
        tick();
        start = 1'b1; tick(); start = 1'b0;
        @(negedge clock); chk("mem0 kept", alu_inst, 12'h105);
        tick();
        repeat (6) tick();

        // Asynchronous reset in the middle of a run
        len = 15; start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        chk("pre-reset busy", busy, 1'b1);
        #1; reset = 1'b0;
        #1;
        chk("arst busy", busy, 1'b0); chk("arst en", alu_inst_en, 1'b0);
        chk("arst result", result, 8'h00); chk("arst inst", alu_inst, 12'h000);
        tick();
        reset = 1'b1;
        repeat (4) tick();
        chk("post-reset idle", busy, 1'b0);

        // Randomized traffic
        repeat (3000) begin
          if ($urandom_range(0, 299) == 0) begin
            prog_we = 1'b0; start = 1'b0; abort = 1'b0;
            #1; reset = 1'b0;
            tick();
            reset = 1'b1;
          end else begin
            prog_we   = ($urandom_range(0, 3) == 0);
            prog_addr = AW'($urandom);
            prog_data = 12'($urandom);
            start     = ($urandom_range(0, 4) == 0);
            start_clr = 1'($urandom_range(0, 1));
            abort     = ($urandom_range(0, 24) == 0);
            if (sched.size() == 0) len = AW'($urandom_range(0, 15));
            tick();
          end
        end
        prog_we = 1'b0; start = 1'b0; abort = 1'b0;
        repeat (25) tick();

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
      end
    join
  end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter: ADDR_W, 4, program memory address width; depth = 2^ADDR_W instructions.
REQ-002 Port: clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low reset.
REQ-004 Port: prog_we  input  1  program memory write strobe.
REQ-005 Port: prog_addr  input  ADDR_W  program memory write address.
REQ-006 Port: prog_data  input  12  instruction word to write ({opcode[3:0], imm[7:0]}).
REQ-007 Port: len  input  ADDR_W  index of last instruction to run (program runs entries 0..len inclusive).
REQ-008 Port: start  input  1  begin a run; sampled only in IDLE.
REQ-009 Port: start_clr  input  1  with start: prepend LDI 00 (12'h100) before entry 0.
REQ-010 Port: abort  input  1  terminate current run.
REQ-011 Port: alu_inst  output  12  instruction to ALU.
REQ-012 Port: alu_inst_en  output  1  ALU instruction enable.
REQ-013 Port: alu_result  input  8  ALU accumulator value.
REQ-014 Port: result  output  8  accumulator captured at end of last completed run.
REQ-015 Port: busy  output  1  high in any state other than IDLE.
REQ-016 Port: done  output  1  one-cycle pulse; result valid in same cycle.
REQ-017 Port: aborted  output  1  one-cycle pulse after an abort.

Function
REQ-018 States SHALL be IDLE, CLEAR, RUN, DRAIN; encoding outside these SHALL go to IDLE next cycle.
REQ-019 Program memory: 2^ADDR_W x 12 registers; write at edge when prog_we=1 and state=IDLE; prog_we in any other state ignored.
REQ-020 IDLE, start=1: start_clr=1 -> CLEAR, else -> RUN; pc <= 0 in both cases.
REQ-021 CLEAR (exactly one cycle): alu_inst=12'h100, alu_inst_en=1 (unless abort); -> RUN.
REQ-022 RUN: alu_inst=mem[pc] (combinational read), alu_inst_en=1 (unless abort); pc==len -> DRAIN, else pc <= pc+1; no wrap, pc never exceeds len.
REQ-023 DRAIN (one cycle, alu_inst_en=0): at its closing edge result <= alu_result, done <= 1, -> IDLE.
REQ-024 Latency: start sampled at edge T, no clear -> done high in cycle T+3+len; with clear -> T+4+len.
REQ-025 alu_inst_en SHALL be 0 in IDLE and DRAIN; alu_inst SHALL be 12'h000 whenever alu_inst_en=0.
REQ-026 abort=1 in CLEAR/RUN/DRAIN: alu_inst_en forced 0 same cycle (combinational), -> IDLE, aborted <= 1, result unchanged, done not asserted; abort in IDLE ignored.
REQ-027 start asserted while busy SHALL be ignored (not queued).
REQ-028 IDLE with prog_we and start same cycle: write completes at that edge; run reads updated contents.
REQ-029 done and aborted SHALL never be high in the same cycle; each lasts exactly one cycle.

Reset
REQ-030 reset=0 SHALL immediately force state=IDLE, pc=0, result=8'h00, done=0, aborted=0, alu_inst_en=0, alu_inst=12'h000, busy=0.
REQ-031 Program memory contents SHALL be unaffected by reset (undefined after power-up).
REQ-032 Reset deassertion SHALL take effect at the next rising edge; no run starts without a new start.

Verification
REQ-033 Load {0:12'h105, 1:12'h203, 2:12'h800}, len=2, start at T -> alu_inst 105,203,800 in T+1..T+3, done=1 with result=8'h10 at T+5.
REQ-034 Load {0:12'h207}, len=0, start+start_clr at T (ALU acc=8'h3C) -> 100 at T+1, 207 at T+2, done with result=8'h07 at T+4.
REQ-035 16-entry program, abort during pc=5 -> alu_inst_en=0 that cycle, aborted=1 next cycle, busy=0, result holds prior value, no done.
REQ-036 During a run, start=1 and prog_we=1 (addr 0, 12'h1FF) -> run unaffected, single done; mem[0] unchanged on rerun.
REQ-037 reset=0 mid-RUN between edges -> busy, alu_inst_en, result go 0 immediately; after release, idle until start.
